// File: rtl/lsu_axi_master.sv
// lsu_axi_master: single-outstanding load/store unit with an AXI4-Lite master port.
// Steers bytes onto the bus lanes, builds write strobes, and sign/zero-extends load data.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned accesses return error 2 without
// touching the bus; when undefined, the offset is rounded down to the access size.
module lsu_axi_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_err,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [STRB_WIDTH-1:0] wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    localparam int OFF_W = $clog2(STRB_WIDTH);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, RESP} state_t;

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [OFF_W-1:0]      r_off;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_err;
    logic                  r_aw_done, r_w_done;

    logic [OFF_W-1:0] w_off, w_mask, w_off_al;
    logic             w_misalign, w_illegal, w_accept;
    logic [1:0]       w_pre_err;
    logic             w_req_ready, w_arvalid, w_rready, w_awvalid, w_wvalid, w_bready, w_rsp_valid;

    // Low bits of (access bytes - 1): nonzero offset bits under this mask mean misaligned.
    function automatic logic [OFF_W-1:0] size_mask(input logic [1:0] size);
        logic [7:0] m;
        m = (8'd1 << size) - 8'd1;
        return m[OFF_W-1:0];
    endfunction

    // Byte-enable pattern for the access size, shifted to its lane.
    function automatic logic [STRB_WIDTH-1:0] strobe(input logic [1:0] size, input logic [OFF_W-1:0] off);
        logic [7:0] b;
        case (size)
            2'd0:    b = 8'h01;
            2'd1:    b = 8'h03;
            2'd2:    b = 8'h0F;
            default: b = 8'hFF;
        endcase
        return STRB_WIDTH'(b) << off;
    endfunction

    // Keep the low bytes of the lane for the access size and widen to the bus width.
    function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] lane,
                                                     input logic [1:0] size, input logic uns);
        logic [DATA_WIDTH-1:0] res;
        case (size)
            2'd0: if (uns) res = DATA_WIDTH'(lane[7:0]);  else res = DATA_WIDTH'($signed(lane[7:0]));
            2'd1: if (uns) res = DATA_WIDTH'(lane[15:0]); else res = DATA_WIDTH'($signed(lane[15:0]));
            2'd2: if (uns) res = DATA_WIDTH'(lane[31:0]); else res = DATA_WIDTH'($signed(lane[31:0]));
            default: res = lane;
        endcase
        return res;
    endfunction

    assign w_off     = req_addr[OFF_W-1:0];
    assign w_mask    = size_mask(req_size);
    assign w_illegal = (req_size == 2'd3) && (DATA_WIDTH == 32);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_off_al   = w_off;
    assign w_misalign = |(w_off & w_mask);
`else
    assign w_off_al   = w_off & ~w_mask;
    assign w_misalign = 1'b0;
`endif

    assign w_pre_err = w_illegal ? 2'd3 : (w_misalign ? 2'd2 : 2'd0);
    assign w_accept  = w_req_ready && req_valid && !rst;

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state and channel handshake controls.
    always_comb begin
        w_next      = r_state;
        w_req_ready = 1'b0;
        w_arvalid   = 1'b0;
        w_rready    = 1'b0;
        w_awvalid   = 1'b0;
        w_wvalid    = 1'b0;
        w_bready    = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid) begin
                    if (w_pre_err != 2'd0) w_next = RESP;
                    else if (req_wen)      w_next = WR_ADDR_DATA;
                    else                   w_next = RD_ADDR;
                end
            end
            RD_ADDR: begin
                w_arvalid = 1'b1;
                if (arready) w_next = RD_DATA;
            end
            RD_DATA: begin
                w_rready = 1'b1;
                if (rvalid) w_next = RESP;
            end
            WR_ADDR_DATA: begin
                w_awvalid = !r_aw_done;
                w_wvalid  = !r_w_done;
                if ((r_aw_done || awready) && (r_w_done || wready)) w_next = WR_RESP;
            end
            WR_RESP: begin
                w_bready = 1'b1;
                if (bvalid) w_next = RESP;
            end
            RESP: begin
                w_rsp_valid = 1'b1;
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Track the independent AW and W handshakes of a store.
    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (r_state == WR_ADDR_DATA) begin
            if (awready) r_aw_done <= 1'b1;
            if (wready)  r_w_done  <= 1'b1;
        end
    end

    // Request capture and response data; only observed through state-qualified outputs.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr     <= {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_off      <= w_off_al;
            r_wdata    <= req_wdata << {w_off_al, 3'b000};
            r_wstrb    <= strobe(req_size, w_off_al);
            r_rdata    <= '0;
            r_err      <= w_pre_err;
        end else if (r_state == RD_DATA && rvalid) begin
            r_rdata <= extend(rdata >> {r_off, 3'b000}, r_size, r_unsigned);
            r_err   <= (rresp != 2'b00) ? 2'd1 : 2'd0;
        end else if (r_state == WR_RESP && bvalid) begin
            r_err <= (bresp != 2'b00) ? 2'd1 : 2'd0;
        end
    end

    assign req_ready = w_req_ready && !rst;
    assign arvalid   = w_arvalid   && !rst;
    assign rready    = w_rready    && !rst;
    assign awvalid   = w_awvalid   && !rst;
    assign wvalid    = w_wvalid    && !rst;
    assign bready    = w_bready    && !rst;
    assign rsp_valid = w_rsp_valid && !rst;
    assign araddr    = (r_state == RD_ADDR && !rst) ? r_addr : '0;
    assign awaddr    = (r_state == WR_ADDR_DATA && !rst) ? r_addr : '0;
    assign wdata     = (r_state == WR_ADDR_DATA && !rst) ? r_wdata : '0;
    assign wstrb     = (r_state == WR_ADDR_DATA && !rst) ? r_wstrb : '0;
    assign rsp_rdata = (r_state == RESP && !rst) ? r_rdata : '0;
    assign rsp_err   = (r_state == RESP && !rst) ? r_err : 2'd0;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed testbench for lsu_axi_master (DATA_WIDTH = 32).
module tb_lsu_axi_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    integer n_checks = 0;
    integer n_fail   = 0;

    lsu_axi_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_slave();
        arready = 0; rvalid = 0; rdata = '0; rresp = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        rsp_ready = 0;
    endtask

    task automatic set_req(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wd);
        req_valid = 1; req_wen = wen; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wd;
    endtask

    task automatic test_reset();
        rst = 1; req_valid = 0; req_wen = 0; req_addr = '0; req_size = 0;
        req_unsigned = 0; req_wdata = '0;
        idle_slave();
        tick(); tick();
        n_checks++;
        if ({req_ready, arvalid, rready, awvalid, wvalid, bready, rsp_valid} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {req_ready, arvalid, rready, awvalid, wvalid, bready, rsp_valid});
        end
        rst = 0;
        tick();
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_load_byte();
        arready = 1; rvalid = 1; rdata = 32'h80FF1234; rresp = 0;
        set_req(0, 32'h80000003, 2'd0, 0, '0);
        tick();
        req_valid = 0;
        n_checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h80000000) begin
            n_fail++; $display("FAIL lb_ar: got arvalid=%b araddr=%h expected 1 80000000", arvalid, araddr);
        end
        tick();
        n_checks++;
        if (rready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL lb_rdata_phase: got rready=%b rsp_valid=%b expected 1 0", rready, rsp_valid);
        end
        tick();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFFFFFF80 || rsp_err !== 2'd0) begin
            n_fail++; $display("FAIL lb_rsp: got v=%b d=%h e=%0d expected 1 ffffff80 0", rsp_valid, rsp_rdata, rsp_err);
        end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL lb_done: got rsp_valid=%b req_ready=%b expected 0 1", rsp_valid, req_ready);
        end
        idle_slave();
    endtask

    task automatic test_store_half();
        int seen;
        wready = 1; awready = 0;
        set_req(1, 32'h80000002, 2'd1, 0, 32'h0000BEEF);
        tick();
        req_valid = 0;
        n_checks++;
        if (awvalid !== 1 || wvalid !== 1 || awaddr !== 32'h80000000 || wdata !== 32'hBEEF0000 || wstrb !== 4'b1100) begin
            n_fail++;
            $display("FAIL sh_issue: got aw=%b w=%b awaddr=%h wdata=%h wstrb=%b expected 1 1 80000000 beef0000 1100",
                     awvalid, wvalid, awaddr, wdata, wstrb);
        end
        tick();
        n_checks++;
        if (wvalid !== 1'b0 || awvalid !== 1'b1) begin
            n_fail++; $display("FAIL sh_w_drop: got wvalid=%b awvalid=%b expected 0 1", wvalid, awvalid);
        end
        tick(); tick();
        awready = 1;
        n_checks++;
        if (awvalid !== 1'b1) begin
            n_fail++; $display("FAIL sh_aw_hold: got awvalid=%b expected 1", awvalid);
        end
        tick();
        awready = 0;
        n_checks++;
        if (awvalid !== 1'b0 || bready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL sh_wresp: got awvalid=%b bready=%b rsp_valid=%b expected 0 1 0", awvalid, bready, rsp_valid);
        end
        bvalid = 1; bresp = 0;
        tick();
        bvalid = 0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 2'd0 || rsp_rdata !== 32'h0) begin
            n_fail++; $display("FAIL sh_rsp: got v=%b e=%0d d=%h expected 1 0 0", rsp_valid, rsp_err, rsp_rdata);
        end
        rsp_ready = 1;
        tick();
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid === 1'b1) seen++;
            tick();
        end
        rsp_ready = 0;
        n_checks++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL sh_single_rsp: got %0d extra responses expected 0", seen);
        end
        idle_slave();
    endtask

    task automatic test_load_bus_error();
        int k;
        arready = 1; rvalid = 1; rdata = 32'h12345678; rresp = 2'b10;
        set_req(0, 32'h80000010, 2'd2, 0, '0);
        tick();
        req_valid = 0;
        for (k = 0; k < 20 && rsp_valid !== 1'b1; k++) tick();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 2'd1 || rsp_rdata !== 32'h12345678) begin
            n_fail++; $display("FAIL lw_buserr: got v=%b e=%0d d=%h expected 1 1 12345678", rsp_valid, rsp_err, rsp_rdata);
        end
        rsp_ready = 1; tick(); rsp_ready = 0;
        idle_slave();
    endtask

    task automatic test_rsp_backpressure();
        int k;
        int bad;
        arready = 1; rvalid = 1; rdata = 32'h80010000; rresp = 0;
        set_req(0, 32'h80000006, 2'd1, 1, '0);
        tick();
        set_req(1, 32'h80000001, 2'd0, 0, 32'h000000A5);
        for (k = 0; k < 20 && rsp_valid !== 1'b1; k++) tick();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h00008001 || rsp_err !== 2'd0 || req_ready !== 1'b0) bad++;
            tick();
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL bp_hold: got %0d unstable cycles (d=%h) expected 0 (d=00008001)", bad, rsp_rdata);
        end
        idle_slave();
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || awvalid !== 1'b0) begin
            n_fail++; $display("FAIL bp_release: got v=%b rr=%b aw=%b expected 0 1 0", rsp_valid, req_ready, awvalid);
        end
        awready = 1; wready = 1; bvalid = 1;
        tick();
        req_valid = 0;
        n_checks++;
        if (awvalid !== 1 || wdata !== 32'h0000A500 || wstrb !== 4'b0010) begin
            n_fail++; $display("FAIL bp_second: got aw=%b wdata=%h wstrb=%b expected 1 0000a500 0010", awvalid, wdata, wstrb);
        end
        for (k = 0; k < 20 && rsp_valid !== 1'b1; k++) tick();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 2'd0) begin
            n_fail++; $display("FAIL bp_second_rsp: got v=%b e=%0d expected 1 0", rsp_valid, rsp_err);
        end
        idle_slave();
        rsp_ready = 1; tick(); rsp_ready = 0;
    endtask

    task automatic test_misalign();
        int k;
        arready = 1; rvalid = 1; rdata = 32'hCAFEF00D; rresp = 0;
        set_req(0, 32'h80000001, 2'd2, 0, '0);
        tick();
        req_valid = 0;
`ifdef LSU_MISALIGN_TRAP_EN
        n_checks++;
        if (arvalid !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 2'd2 || rsp_rdata !== 32'h0) begin
            n_fail++; $display("FAIL mis_trap: got ar=%b v=%b e=%0d d=%h expected 0 1 2 0", arvalid, rsp_valid, rsp_err, rsp_rdata);
        end
        rsp_ready = 1; tick(); rsp_ready = 0;
`else
        n_checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h80000000) begin
            n_fail++; $display("FAIL mis_issue: got ar=%b araddr=%h expected 1 80000000", arvalid, araddr);
        end
        for (k = 0; k < 20 && rsp_valid !== 1'b1; k++) tick();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 2'd0 || rsp_rdata !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL mis_word: got v=%b e=%0d d=%h expected 1 0 cafef00d", rsp_valid, rsp_err, rsp_rdata);
        end
        rsp_ready = 1; tick(); rsp_ready = 0;
        rdata = 32'hABCD0000;
        set_req(0, 32'h80000003, 2'd1, 1, '0);
        tick();
        req_valid = 0;
        for (k = 0; k < 20 && rsp_valid !== 1'b1; k++) tick();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 2'd0 || rsp_rdata !== 32'h0000ABCD) begin
            n_fail++; $display("FAIL mis_half: got v=%b e=%0d d=%h expected 1 0 0000abcd", rsp_valid, rsp_err, rsp_rdata);
        end
        rsp_ready = 1; tick(); rsp_ready = 0;
`endif
        idle_slave();
    endtask

    task automatic test_illegal_size();
        arready = 1; rvalid = 1;
        set_req(0, 32'h80000000, 2'd3, 0, '0);
        tick();
        req_valid = 0;
        n_checks++;
        if (arvalid !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 2'd3) begin
            n_fail++; $display("FAIL illegal_size: got ar=%b v=%b e=%0d expected 0 1 3", arvalid, rsp_valid, rsp_err);
        end
        rsp_ready = 1; tick(); rsp_ready = 0;
        idle_slave();
    endtask

    task automatic test_reset_in_flight();
        int seen;
        int k;
        awready = 1; wready = 1; bvalid = 0;
        set_req(1, 32'h80000020, 2'd2, 0, 32'h11223344);
        tick();
        req_valid = 0;
        tick();
        n_checks++;
        if (bready !== 1'b1) begin
            n_fail++; $display("FAIL rif_in_wresp: got bready=%b expected 1", bready);
        end
        rst = 1;
        #1;
        n_checks++;
        if ({req_ready, arvalid, rready, awvalid, wvalid, bready, rsp_valid} !== 7'b0) begin
            n_fail++; $display("FAIL rif_during_rst: got %b expected 0000000",
                               {req_ready, arvalid, rready, awvalid, wvalid, bready, rsp_valid});
        end
        tick(); tick();
        rst = 0;
        bvalid = 1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid === 1'b1 || req_ready !== 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL rif_no_rsp: got %0d bad cycles expected 0", seen);
        end
        idle_slave();
        arready = 1; rvalid = 1; rdata = 32'h00AB0000;
        set_req(0, 32'h80000002, 2'd0, 1, '0);
        tick();
        req_valid = 0;
        for (k = 0; k < 20 && rsp_valid !== 1'b1; k++) tick();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 2'd0 || rsp_rdata !== 32'h000000AB) begin
            n_fail++; $display("FAIL rif_fresh_load: got v=%b e=%0d d=%h expected 1 0 000000ab", rsp_valid, rsp_err, rsp_rdata);
        end
        rsp_ready = 1; tick(); rsp_ready = 0;
        idle_slave();
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_store_half();
        test_load_bus_error();
        test_rsp_backpressure();
        test_misalign();
        test_illegal_size();
        test_reset_in_flight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
- Parametrised load/store unit and AXI4-Lite master that sits between the execute stage and the data-memory interconnect (SRAM model, UART, CLINT and similar targets).
- Accepts one memory request at a time over a valid/ready handshake.
- Drives either the AR/R channels or the independent AW/W/B channels, performs byte-lane steering and sign/zero extension, and returns a response carrying read data and an error code.
- Supports 32- and 64-bit data buses.

Parameters:
- DATA_WIDTH, 32, bus and register data width; legal values are 32 and 64.
- ADDR_WIDTH, 32, byte address width.
- STRB_WIDTH, DATA_WIDTH/8, write-strobe width; derived, must not be overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid and req_ready are both high.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- req_unsigned  in  1  zero-extend load data when high; sign-extend when low.
- req_wdata  in  DATA_WIDTH  store data, right-aligned (least-significant bytes).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores.
- rsp_err  out  2  0 = OK, 1 = bus error, 2 = misaligned, 3 = illegal size.
- araddr / arvalid / arready  out / out / in  ADDR_WIDTH / 1 / 1  AXI read-address channel.
- rdata / rresp / rvalid / rready  in / in / in / out  DATA_WIDTH / 2 / 1 / 1  AXI read-data channel.
- awaddr / awvalid / awready  out / out / in  ADDR_WIDTH / 1 / 1  AXI write-address channel.
- wdata / wstrb / wvalid / wready  out / out / out / in  DATA_WIDTH / STRB_WIDTH / 1 / 1  AXI write-data channel.
- bresp / bvalid / bready  in / in / out  2 / 1 / 1  AXI write-response channel.

Behaviour:
- Reset: clk is the clock; rst is synchronous, active-high.
  - While rst is high, every output is 0, including req_ready.
  - The FSM is in IDLE.
  - A transaction in flight when rst rises is abandoned: no response is produced and all valids are low on the cycle after the rst edge.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, RESP.
- IDLE:
  - req_ready = 1 in IDLE only. At most one request is in flight.
  - On accept, latch addr, size, unsigned, wen and wdata.
  - Next state is RD_ADDR (load), WR_ADDR_DATA (store), or RESP (error precheck failed, see below).
- Byte offset and bus address:
  - off = addr[log2(STRB_WIDTH)-1:0].
  - araddr and awaddr = addr with the offset bits cleared.
  - Both are held stable while the corresponding valid is high.
- RD_ADDR:
  - arvalid = 1 until the arready handshake, then go to RD_DATA.
  - rready = 0 in RD_ADDR.
- RD_DATA:
  - rready = 1.
  - On rvalid, take lane = rdata >> (8*off) and keep the low 8, 16, 32 or 64 bits per size.
  - Extend to DATA_WIDTH: sign-extend unless req_unsigned is set.
  - rsp_err = 1 if rresp != 0; rdata is still returned.
  - Go to RESP.
- WR_ADDR_DATA:
  - On entry, awvalid and wvalid both rise in the same cycle.
  - wdata = req_wdata << (8*off).
  - wstrb = ((1 << (1 << size)) - 1) << off.
  - Each valid drops independently after its own handshake; either order and the simultaneous case are legal.
  - Go to WR_RESP once both handshakes are complete.
- WR_RESP:
  - bready = 1.
  - On bvalid, rsp_err = (bresp != 0) ? 1 : 0.
  - Go to RESP.
- RESP:
  - rsp_valid = 1, with rsp_rdata and rsp_err held stable until rsp_ready.
  - Then return to IDLE.
  - No new request is accepted in the cycle rsp_ready is sampled.
- Illegal size: req_size = 3 with DATA_WIDTH = 32 produces no bus activity; go directly to RESP with rsp_err = 3.
- Latency with an always-ready, zero-wait slave:
  - Accept at cycle N.
  - arvalid or awvalid at N+1.
  - rvalid or bvalid at N+2.
  - rsp_valid at N+3.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A request whose off is not a multiple of the access size (1 << size) issues no bus transaction.
  - The FSM goes directly to RESP with rsp_err = 2 and rsp_rdata = 0.
- Undefined:
  - No alignment check is performed; off is truncated to a multiple of the access size before steering and strobe generation.
  - Example: a half access at offset 3 uses offset 2.
  - rsp_err is never 2.

Test Plan:
1. DATA_WIDTH = 32, load byte, addr 0x80000003, signed, rdata = 0x80FF1234 with OKAY -> araddr 0x80000000; rsp_rdata 0xFFFFFF80; rsp_err 0; rsp_valid 3 cycles after accept.
2. Store half, addr 0x80000002, wdata 0x0000BEEF; awready delayed 3 cycles while wready is immediate -> wdata 0xBEEF0000; wstrb 4'b1100; wvalid drops after 1 cycle and awvalid after 4; a single response with rsp_err 0.
3. Load word, rresp = 2'b10, rdata 0x12345678 -> rsp_err 1; rsp_rdata 0x12345678.
4. rsp_ready held low for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable; req_ready stays 0; a second request is accepted only after the response handshake.
5. With LSU_MISALIGN_TRAP_EN, load word at 0x80000001 -> arvalid never rises; rsp_err 2 at accept+1. Without the macro -> the access is issued at 0x80000000 with rsp_err 0.
6. Assert rst while in WR_RESP (bvalid still low) -> all valids 0 and req_ready 0 while in reset; no rsp_valid afterwards; a fresh load completes normally after reset is released.
